// File: rtl/df96_to_int.sv
// DF96 decimal float to 96-bit signed/unsigned integer: align, BCD accumulate, scale, round, saturate.
// Finite result after A+20+S+2 enabled cycles (specials after 2); ld restarts at any time, ce stalls everything.
module df96_to_int (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic        ld,
  input  logic        op,
  input  logic [2:0]  rm,
  input  logic [95:0] i,
  output logic [95:0] o,
  output logic        done,
  output logic        ovf
);

  typedef enum logic [2:0] {IDLE, ALIGN, CONV, SCALE, ROUND, FIN} state_t;

  state_t        state_q, state_d;
  logic [79:0]   sig_q, sig_d;
  logic [99:0]   acc_q, acc_d;
  logic [3:0]    rd_q, rd_d;
  logic          sticky_q, sticky_d;
  logic          big_q, big_d;
  logic          sign_q, sign_d;
  logic          op_q, op_d;
  logic [2:0]    rm_q, rm_d;
  logic          nan_q, nan_d;
  logic          inf_q, inf_d;
  logic [4:0]    cnt_q, cnt_d;
  logic [4:0]    scl_q, scl_d;
  logic [95:0]   o_q, o_d;
  logic          ovf_q, ovf_d;
  logic          done_q, done_d;

  // Operand decode at load time
  logic [14:0]        ld_exp;
  logic signed [16:0] ld_e;
  logic signed [16:0] ld_ne;
  logic               ld_spc;
  logic               ld_neg;
  logic [4:0]         ld_acnt;
  logic [4:0]         ld_scnt;

  assign ld_exp  = i[94:80];
  assign ld_e    = $signed({2'b00, ld_exp}) - 17'sd16383;
  assign ld_ne   = -ld_e;
  assign ld_spc  = &ld_exp;
  assign ld_neg  = ld_e[16];
  assign ld_acnt = (ld_ne > 17'sd21) ? 5'd21 : ld_ne[4:0];
  assign ld_scnt = ld_neg ? 5'd0 : ((ld_e > 17'sd29) ? 5'd29 : ld_e[4:0]);

  logic round_up;
  logic any_frac;
  logic over;

  assign any_frac = (rd_q != 4'd0) | sticky_q;
  assign over     = big_q | inf_q | (|acc_q[99:96]);

  always_comb begin
    round_up = 1'b0;
    case (rm_q)
      3'd1:    round_up = 1'b0;
      3'd2:    round_up = any_frac & ~sign_q;
      3'd3:    round_up = any_frac & sign_q;
      3'd4:    round_up = (rd_q >= 4'd5);
      default: round_up = (rd_q > 4'd5) | ((rd_q == 4'd5) & (sticky_q | acc_q[0]));
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else if (ce) begin
      state_q <= state_d;
    end
  end

  // Specials route through ROUND (rd and sticky are clear) so they finish in two cycles
  always_comb begin
    state_d = state_q;
    if (ld) begin
      state_d = ld_spc ? ROUND : (ld_neg ? ALIGN : CONV);
    end else begin
      case (state_q)
        ALIGN:   if (cnt_q == 5'd0) state_d = CONV;
        CONV:    if (cnt_q == 5'd0) state_d = (scl_q != 5'd0) ? SCALE : ROUND;
        SCALE:   if (cnt_q == 5'd0) state_d = ROUND;
        ROUND:   state_d = FIN;
        FIN:     state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    sig_d    = sig_q;
    acc_d    = acc_q;
    rd_d     = rd_q;
    sticky_d = sticky_q;
    big_d    = big_q;
    sign_d   = sign_q;
    op_d     = op_q;
    rm_d     = rm_q;
    nan_d    = nan_q;
    inf_d    = inf_q;
    cnt_d    = cnt_q;
    scl_d    = scl_q;
    o_d      = o_q;
    ovf_d    = ovf_q;
    done_d   = done_q;
    if (ld) begin
      sig_d    = i[79:0];
      acc_d    = '0;
      rd_d     = 4'd0;
      sticky_d = 1'b0;
      big_d    = 1'b0;
      sign_d   = i[95];
      op_d     = op;
      rm_d     = rm;
      nan_d    = ld_spc & (|i[79:0]);
      inf_d    = ld_spc & ~(|i[79:0]);
      cnt_d    = ld_neg ? (ld_acnt - 5'd1) : 5'd19;
      scl_d    = ld_scnt;
      done_d   = 1'b0;
    end else begin
      case (state_q)
        ALIGN: begin
          sig_d    = {4'h0, sig_q[79:4]};
          rd_d     = sig_q[3:0];
          sticky_d = sticky_q | (rd_q != 4'd0);
          cnt_d    = (cnt_q == 5'd0) ? 5'd19 : (cnt_q - 5'd1);
        end
        CONV: begin
          acc_d = (acc_q << 3) + (acc_q << 1) + {96'd0, sig_q[79:76]};
          sig_d = {sig_q[75:0], 4'h0};
          cnt_d = (cnt_q == 5'd0) ? (scl_q - 5'd1) : (cnt_q - 5'd1);
        end
        SCALE: begin
          // Once past 2^96 the value is saturated anyway; freezing acc keeps it inside 100 bits
          if (big_q || (|acc_q[99:96])) begin
            big_d = 1'b1;
          end else begin
            acc_d = (acc_q << 3) + (acc_q << 1);
          end
          cnt_d = cnt_q - 5'd1;
        end
        ROUND: begin
          if (round_up) acc_d = acc_q + 100'd1;
        end
        FIN: begin
          done_d = 1'b1;
          if (nan_q) begin
            o_d   = '0;
            ovf_d = 1'b1;
          end else if (!op_q) begin
            if (sign_q) begin
              o_d   = '0;
              ovf_d = over | (acc_q != 100'd0);
            end else if (over) begin
              o_d   = '1;
              ovf_d = 1'b1;
            end else begin
              o_d   = acc_q[95:0];
              ovf_d = 1'b0;
            end
          end else if (!sign_q) begin
            if (over || acc_q[95]) begin
              o_d   = {1'b0, {95{1'b1}}};
              ovf_d = 1'b1;
            end else begin
              o_d   = acc_q[95:0];
              ovf_d = 1'b0;
            end
          end else begin
            if (over || (acc_q[95] && (|acc_q[94:0]))) begin
              o_d   = {1'b1, 95'd0};
              ovf_d = 1'b1;
            end else begin
              o_d   = 96'd0 - acc_q[95:0];
              ovf_d = 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sig_q    <= '0;
      acc_q    <= '0;
      rd_q     <= 4'd0;
      sticky_q <= 1'b0;
      big_q    <= 1'b0;
      sign_q   <= 1'b0;
      op_q     <= 1'b0;
      rm_q     <= 3'd0;
      nan_q    <= 1'b0;
      inf_q    <= 1'b0;
      cnt_q    <= 5'd0;
      scl_q    <= 5'd0;
      o_q      <= '0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else if (ce) begin
      sig_q    <= sig_d;
      acc_q    <= acc_d;
      rd_q     <= rd_d;
      sticky_q <= sticky_d;
      big_q    <= big_d;
      sign_q   <= sign_d;
      op_q     <= op_d;
      rm_q     <= rm_d;
      nan_q    <= nan_d;
      inf_q    <= inf_d;
      cnt_q    <= cnt_d;
      scl_q    <= scl_d;
      o_q      <= o_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
    end
  end

  assign o    = o_q;
  assign ovf  = ovf_q;
  assign done = done_q;

endmodule

// File: tb/tb_df96_to_int.sv
// Bench for df96_to_int: directed cases plus random operands against an arithmetic reference model.
module tb_df96_to_int;

  logic        clk;
  logic        rst;
  logic        ce;
  logic        ld;
  logic        op;
  logic [2:0]  rm;
  logic [95:0] i;
  logic [95:0] o;
  logic        done;
  logic        ovf;

  df96_to_int dut (
    .clk (clk),
    .rst (rst),
    .ce  (ce),
    .ld  (ld),
    .op  (op),
    .rm  (rm),
    .i   (i),
    .o   (o),
    .done(done),
    .ovf (ovf)
  );

  typedef struct {
    logic [95:0] o;
    logic        ovf;
    int          due;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   ncmp;
  int   nfail;
  int   cyc;
  int   k_last;
  logic done_prev;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] want);
    ncmp++;
    if (act !== want) begin
      nfail++;
      $display("FAIL %s: got %h want %h", nm, act, want);
    end
  endtask

  // Reference: exact decimal value, scaled/divided by powers of ten, then rounded and saturated
  function automatic exp_t model(input logic [95:0] iv, input logic opv, input logic [2:0] rmv);
    exp_t         r;
    logic [255:0] sig, p, q, rem, half, mag;
    logic [95:0]  m96;
    logic         neg, up;
    int           e, a, sc;
    sig = 0;
    for (int d = 19; d >= 0; d--) sig = sig * 10 + 256'(iv[d*4 +: 4]);
    neg = iv[95];
    r.o = '0;
    r.ovf = 1'b0;
    if (iv[94:80] == 15'h7FFF) begin
      r.due = 2;
      if (sig != 0) begin
        r.ovf = 1'b1;
        return r;
      end
      mag = 256'd1 << 200;
    end else begin
      e = int'(iv[94:80]) - 16383;
      if (e < 0) begin
        a = (-e > 21) ? 21 : -e;
        p = 1;
        repeat (a) p = p * 10;
        q = sig / p;
        rem = sig % p;
        half = p / 2;
        case (rmv)
          3'd1:    up = 1'b0;
          3'd2:    up = (rem != 0) && !neg;
          3'd3:    up = (rem != 0) && neg;
          3'd4:    up = (rem >= half);
          default: up = (rem > half) || ((rem == half) && q[0]);
        endcase
        mag = q + 256'(up);
        r.due = a + 22;
      end else begin
        sc = (e > 29) ? 29 : e;
        mag = sig;
        repeat (sc) mag = mag * 10;
        r.due = sc + 22;
      end
    end
    if (!opv) begin
      if (neg) begin
        r.o = '0;
        r.ovf = (mag != 0);
      end else if (mag > ((256'd1 << 96) - 1)) begin
        r.o = '1;
        r.ovf = 1'b1;
      end else begin
        r.o = mag[95:0];
      end
    end else if (!neg) begin
      if (mag > ((256'd1 << 95) - 1)) begin
        r.o = {1'b0, {95{1'b1}}};
        r.ovf = 1'b1;
      end else begin
        r.o = mag[95:0];
      end
    end else begin
      if (mag > (256'd1 << 95)) begin
        r.o = {1'b1, 95'd0};
        r.ovf = 1'b1;
      end else begin
        m96 = mag[95:0];
        r.o = ~m96 + 96'd1;
      end
    end
    return r;
  endfunction

  // Called at a negedge; ld is sampled at the following posedge (edge k_last)
  task automatic issue(input logic [95:0] iv, input logic opv, input logic [2:0] rmv);
    i = iv;
    op = opv;
    rm = rmv;
    ld = 1'b1;
    k_last = cyc + 1;
    @(negedge clk);
    ld = 1'b0;
  endtask

  task automatic push_exp(input logic [95:0] eo, input logic eovf, input int lat);
    exp_t x;
    x.o = eo;
    x.ovf = eovf;
    x.due = k_last + lat;
    sb.push_back(x);
  endtask

  task automatic push_model(input logic [95:0] iv, input logic opv, input logic [2:0] rmv, input int extra);
    exp_t x;
    x = model(iv, opv, rmv);
    x.due = k_last + x.due + extra;
    sb.push_back(x);
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 300 && sb.size() != 0; n++) @(negedge clk);
    if (sb.size() != 0) begin
      ncmp++;
      nfail++;
      $display("FAIL timeout: done not seen, %0d results still pending", sb.size());
      sb.delete();
    end
  endtask

  initial done_prev = 1'b0;
  always @(negedge clk) begin
    if (!rst && done && !done_prev) begin
      if (sb.size() == 0) begin
        ncmp++;
        nfail++;
        $display("FAIL unexpected_done: done rose at edge %0d with nothing pending, o=%h", cyc, o);
      end else begin
        mon_e = sb.pop_front();
        chk("result_o", o, mon_e.o);
        chk("result_ovf", {95'd0, ovf}, {95'd0, mon_e.ovf});
        chk("latency_edge", 96'(cyc), 96'(mon_e.due));
      end
    end
    done_prev = done;
  end

  logic [95:0] opnd;
  logic [79:0] sigv;
  logic [14:0] expv;
  logic        opr;
  logic [2:0]  rmr;
  int          kind;
  int          nd;

  initial begin
    ncmp = 0;
    nfail = 0;
    rst = 1'b1;
    ce = 1'b1;
    ld = 1'b0;
    op = 1'b0;
    rm = 3'd0;
    i = '0;
    repeat (3) @(negedge clk);
    chk("reset_o", o, 96'd0);
    chk("reset_done", {95'd0, done}, 96'd0);
    chk("reset_ovf", {95'd0, ovf}, 96'd0);
    rst = 1'b0;
    @(negedge clk);

    issue({16'h3FFF, 80'h1}, 1'b0, 3'd0);
    push_exp(96'd1, 1'b0, 22);
    wait_idle();
    issue({16'h3FFF, 80'h12345678}, 1'b0, 3'd0);
    push_exp(96'h00BC614E, 1'b0, 22);
    wait_idle();
    issue({16'h3FFF, 80'h99999999999999999999}, 1'b0, 3'd0);
    push_exp(96'h56BC75E2D630FFFFF, 1'b0, 22);
    wait_idle();

    issue({16'h3FFE, 80'h25}, 1'b0, 3'd0); push_exp(96'd2, 1'b0, 23); wait_idle();
    issue({16'h3FFE, 80'h25}, 1'b0, 3'd4); push_exp(96'd3, 1'b0, 23); wait_idle();
    issue({16'h3FFE, 80'h25}, 1'b0, 3'd2); push_exp(96'd3, 1'b0, 23); wait_idle();
    issue({16'h3FFE, 80'h25}, 1'b0, 3'd1); push_exp(96'd2, 1'b0, 23); wait_idle();
    issue({16'h3FFE, 80'h25}, 1'b0, 3'd3); push_exp(96'd2, 1'b0, 23); wait_idle();

    issue({16'hBFFE, 80'h35}, 1'b1, 3'd0); push_exp({{94{1'b1}}, 2'b00}, 1'b0, 23); wait_idle();
    issue({16'hBFFE, 80'h35}, 1'b0, 3'd0); push_exp(96'd0, 1'b1, 23); wait_idle();

    issue({16'h401C, 80'h1}, 1'b1, 3'd0); push_exp({1'b0, {95{1'b1}}}, 1'b1, 51); wait_idle();
    issue({16'h7FFF, 80'h1}, 1'b1, 3'd0); push_exp(96'd0, 1'b1, 2); wait_idle();
    issue({16'h7FFF, 80'h0}, 1'b0, 3'd0); push_exp({96{1'b1}}, 1'b1, 2); wait_idle();
    issue({16'hFFFF, 80'h0}, 1'b1, 3'd0); push_exp({1'b1, 95'd0}, 1'b1, 2); wait_idle();

    // Mid-conversion reset must wipe the previous (nonzero, overflowed) result
    issue({16'h3FFF, 80'h12345678}, 1'b0, 3'd0);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_o", o, 96'd0);
    chk("midrst_done", {95'd0, done}, 96'd0);
    chk("midrst_ovf", {95'd0, ovf}, 96'd0);
    rst = 1'b0;
    repeat (30) @(negedge clk);

    // Clock enable low for three cycles stretches latency by three
    issue({16'h3FFF, 80'h12345678}, 1'b0, 3'd0);
    push_exp(96'h00BC614E, 1'b0, 25);
    repeat (2) @(negedge clk);
    ce = 1'b0;
    repeat (3) @(negedge clk);
    ce = 1'b1;
    wait_idle();

    // Restart at k+5: only the second operand's result may appear
    issue({16'h3FFF, 80'h12345678}, 1'b0, 3'd0);
    repeat (4) @(negedge clk);
    issue({16'h3FFF, 80'h999}, 1'b0, 3'd0);
    push_exp(96'd999, 1'b0, 22);
    wait_idle();
    repeat (30) @(negedge clk);

    for (int t = 0; t < 150; t++) begin
      kind = int'($urandom_range(0, 15));
      nd = int'($urandom_range(0, 20));
      sigv = '0;
      for (int d = 0; d < nd; d++) sigv[d*4 +: 4] = 4'($urandom_range(0, 9));
      if (kind == 0) begin
        expv = 15'h7FFF;
        if ($urandom_range(0, 1) == 0) sigv = '0;
      end else if (kind == 1) begin
        expv = 15'($urandom_range(0, 32766));
      end else begin
        expv = 15'(16383 - 28 + int'($urandom_range(0, 60)));
      end
      opnd = {1'($urandom_range(0, 1)), expv, sigv};
      opr = 1'($urandom_range(0, 1));
      rmr = 3'($urandom_range(0, 7));
      issue(opnd, opr, rmr);
      push_model(opnd, opr, rmr, 0);
      wait_idle();
    end

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
